clk_switch_seq: RTL and testbench



---
 rtl/clk_switch_seq.sv | 99 +++++++++
 tb/tb_clk_switch_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_seq.sv
// Sequences a clock-mux select change: gate the downstream clock, drain, flip select, settle, re-enable.
// One request in flight at a time; req_ready_o is low while a switch is in progress, so valid simply stalls.
module clk_switch_seq #(
  parameter int unsigned GATE_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic        RESET_SEL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  output logic clk_sel_o,
  output logic clk_en_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned MAX_CYCLES = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    SWITCH,
    SETTLE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sel_q;
  logic             tgt_sel_q;
  logic             en_q;
  logic             done_q;
  logic             hs;

  assign hs = req_valid_i && (state_q == IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= RESET_SEL;
      tgt_sel_q <= RESET_SEL;
      en_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            // A request for the select already in use completes without touching the clock.
            if (req_sel_i != sel_q) begin
              tgt_sel_q <= req_sel_i;
              cnt_q     <= GATE_LOAD;
              en_q      <= 1'b0;
              state_q   <= GATE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        GATE: begin
          if (cnt_q == '0) begin
            state_q <= SWITCH;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        SWITCH: begin
          sel_q   <= tgt_sel_q;
          cnt_q   <= SETTLE_LOAD;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign clk_sel_o   = sel_q;
  assign clk_en_o    = en_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_clk_switch_seq.sv
// Two instances (default timing and GATE=SETTLE=1) checked every cycle against a
// timeline model built from handshake-relative offsets, plus directed scenario checks.
module tb_clk_switch_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v;
  logic [1:0] vld_v;
  logic [1:0] sel_v;
  logic [1:0] rdy_w;
  logic [1:0] csel_w;
  logic [1:0] en_w;
  logic [1:0] busy_w;
  logic [1:0] done_w;

  clk_switch_seq #(.GATE_CYCLES(8), .SETTLE_CYCLES(16), .RESET_SEL(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst_v[0]), .req_valid_i(vld_v[0]), .req_sel_i(sel_v[0]),
    .req_ready_o(rdy_w[0]), .clk_sel_o(csel_w[0]), .clk_en_o(en_w[0]),
    .busy_o(busy_w[0]), .done_o(done_w[0])
  );

  clk_switch_seq #(.GATE_CYCLES(1), .SETTLE_CYCLES(1), .RESET_SEL(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst_v[1]), .req_valid_i(vld_v[1]), .req_sel_i(sel_v[1]),
    .req_ready_o(rdy_w[1]), .clk_sel_o(csel_w[1]), .clk_en_o(en_w[1]),
    .busy_o(busy_w[1]), .done_o(done_w[1])
  );

  int gc [2] = '{8, 1};
  int sc [2] = '{16, 1};

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: a switch accepted at edge t0 has outputs fixed by the offset j = edge - t0.
  int act_t0 [2];
  int same_done [2];
  bit cur_sel [2];
  bit new_sel [2];
  bit rst_edge [2];
  int hs_cnt [2];
  bit e_en [2], e_busy [2], e_rdy [2], e_sel [2], e_done [2];

  bit prev_sel [2];
  bit prev_en [2];
  int sel_changes [2];
  int done_cnt [2];
  bit rec_b = 1'b0;
  int done_b [$];

  task automatic cmp(input string tag, input int k, input logic obs, input logic want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s[%0d] cyc=%0d observed=%b expected=%b", tag, k, cyc, obs, want);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, want);
    end
  endtask

  task automatic model_edge(input int k);
    int g, s, j;
    g = gc[k];
    s = sc[k];
    rst_edge[k] = rst_v[k];
    if (act_t0[k] >= 0 && (cyc - 1 - act_t0[k]) >= g + s + 1) begin
      cur_sel[k] = new_sel[k];
      act_t0[k] = -1;
    end
    if (rst_v[k]) begin
      act_t0[k] = -1;
      same_done[k] = -1;
      cur_sel[k] = 1'b0;
    end else if (vld_v[k] && act_t0[k] < 0) begin
      hs_cnt[k]++;
      if (sel_v[k] != cur_sel[k]) begin
        act_t0[k] = cyc;
        new_sel[k] = sel_v[k];
      end else begin
        same_done[k] = cyc;
      end
    end
    if (act_t0[k] >= 0) begin
      j = cyc - act_t0[k];
      e_en[k]   = (j >= g + s + 1);
      e_busy[k] = !(j >= g + s + 1);
      e_rdy[k]  = (j >= g + s + 1);
      e_sel[k]  = (j >= g + 1) ? new_sel[k] : cur_sel[k];
      e_done[k] = (j == g + s + 1);
    end else begin
      e_en[k]   = 1'b1;
      e_busy[k] = 1'b0;
      e_rdy[k]  = 1'b1;
      e_sel[k]  = cur_sel[k];
      e_done[k] = (same_done[k] == cyc);
    end
  endtask

  task automatic check(input int k);
    cmp("clk_en", k, en_w[k], e_en[k]);
    cmp("busy", k, busy_w[k], e_busy[k]);
    cmp("req_ready", k, rdy_w[k], e_rdy[k]);
    cmp("clk_sel", k, csel_w[k], e_sel[k]);
    cmp("done", k, done_w[k], e_done[k]);
    if (csel_w[k] !== prev_sel[k]) begin
      sel_changes[k]++;
      if (!rst_edge[k]) begin
        cmp("sel_change_en_before", k, prev_en[k], 1'b0);
        cmp("sel_change_en_after", k, en_w[k], 1'b0);
      end
    end
    if (done_w[k] === 1'b1) begin
      done_cnt[k]++;
      if (k == 1 && rec_b) done_b.push_back(cyc);
    end
    prev_sel[k] = csel_w[k];
    prev_en[k]  = en_w[k];
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check(0);
    check(1);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int base_chg;
    int base_done;
    int h1;
    int guard;
    for (int k = 0; k < 2; k++) begin
      act_t0[k] = -1;
      same_done[k] = -1;
      cur_sel[k] = 1'b0;
      new_sel[k] = 1'b0;
      hs_cnt[k] = 0;
      prev_sel[k] = 1'b0;
      prev_en[k] = 1'b1;
      sel_changes[k] = 0;
      done_cnt[k] = 0;
    end
    rst_v = 2'b11;
    vld_v = 2'b00;
    sel_v = 2'b00;
    idle(2);
    rst_v = 2'b00;
    idle(5);

    // Real switch 0->1 with default timing.
    vld_v[0] = 1'b1;
    sel_v[0] = 1'b1;
    step();
    vld_v[0] = 1'b0;
    sel_v[0] = 1'b0;
    idle(30);

    // Same-select request completes next cycle, no gating.
    vld_v[0] = 1'b1;
    sel_v[0] = 1'b1;
    step();
    vld_v[0] = 1'b0;
    idle(3);

    // Switch to 0 while req_sel_i wanders; only the latched value counts.
    base_chg = sel_changes[0];
    vld_v[0] = 1'b1;
    sel_v[0] = 1'b0;
    step();
    vld_v[0] = 1'b0;
    repeat (30) begin
      sel_v[0] = 1'($urandom);
      step();
    end
    cmp_int("toggle_sel_changes", sel_changes[0] - base_chg, 1);
    cmp("toggle_final_sel", 0, csel_w[0], 1'b0);

    // Back-to-back on the short instance with valid held high.
    base_chg = sel_changes[1];
    base_done = hs_cnt[1];
    rec_b = 1'b1;
    vld_v[1] = 1'b1;
    sel_v[1] = 1'b1;
    step();
    h1 = cyc;
    sel_v[1] = 1'b0;
    guard = 0;
    while (hs_cnt[1] < base_done + 2 && guard < 20) begin
      step();
      guard++;
    end
    vld_v[1] = 1'b0;
    idle(6);
    rec_b = 1'b0;
    cmp_int("b2b_done_count", done_b.size(), 2);
    if (done_b.size() == 2) begin
      cmp_int("b2b_first_latency", done_b[0] - h1, 3);
      cmp_int("b2b_spacing", done_b[1] - done_b[0], 4);
    end
    cmp_int("b2b_sel_changes", sel_changes[1] - base_chg, 2);

    // Reset during SETTLE after the select has moved to 1.
    vld_v[0] = 1'b1;
    sel_v[0] = 1'b1;
    step();
    vld_v[0] = 1'b0;
    idle(14);
    cmp("pre_reset_sel", 0, csel_w[0], 1'b1);
    base_done = done_cnt[0];
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    cmp("rst_mid_sel", 0, csel_w[0], 1'b0);
    cmp("rst_mid_en", 0, en_w[0], 1'b1);
    cmp("rst_mid_ready", 0, rdy_w[0], 1'b1);
    idle(30);
    cmp_int("rst_mid_no_done", done_cnt[0] - base_done, 0);

    // Random traffic, stalled valids and occasional resets on both instances.
    repeat (400) begin
      for (int k = 0; k < 2; k++) begin
        vld_v[k] = ($urandom_range(0, 3) == 0);
        sel_v[k] = 1'($urandom);
        rst_v[k] = ($urandom_range(0, 99) == 0);
      end
      step();
    end
    rst_v = 2'b00;
    vld_v = 2'b00;
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
